// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_pkg;

  localparam int unsigned NIBBLE_W     = 4;
  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam logic [3:0]  BLANK_NIBBLE = 4'd0;

  // One-hot decode of a digit index; callers slice the low NUM_DIGITS bits.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'b1 << idx;
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot counter and slot index for time-multiplexed scanning (7-seg or LED matrix).
module seg_scan_prescaler #(
  parameter int unsigned NumSlots = 4,
  parameter int unsigned SlotDiv  = 50000,
  localparam int unsigned CntW    = (SlotDiv > 1) ? $clog2(SlotDiv) : 1,
  localparam int unsigned IdxW    = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [CntW-1:0] cnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            wrap_o,
  output logic            frame_wrap_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            wrap;
  logic            last_slot;

  // Slot counter wraps every SlotDiv cycles; slot index steps on each wrap.
  always_comb begin
    wrap      = (cnt_q == CntW'(SlotDiv - 1));
    last_slot = (idx_q == IdxW'(NumSlots - 1));
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (wrap) begin
      idx_d = last_slot ? '0 : idx_q + 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign idx_o        = idx_q;
  assign wrap_o       = wrap;
  assign frame_wrap_o = wrap && last_slot;

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed BCD scan driver feeding a seven_segment decoder (bcd/cs) plus digit enables.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned LZB          = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                           load,
  output logic [NIBBLE_W-1:0]            bcd,
  output logic                           cs,
  output logic [NUM_DIGITS-1:0]          digit_en,
  output logic                           frame_tick,
  output logic                           pending
);

  localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DispW = NIBBLE_W * NUM_DIGITS;

  if (REFRESH_DIV < 2) begin : gen_bad_refresh_div
    $error("REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES >= REFRESH_DIV) begin : gen_bad_blank_cycles
    $error("BLANK_CYCLES must be < REFRESH_DIV");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gen_bad_num_digits
    $error("NUM_DIGITS must be in 1..8");
  end

  logic [CntW-1:0] cnt;
  logic [IdxW-1:0] idx;
  logic            wrap;
  logic            frame_wrap;
  logic            unused_wrap;

  seg_scan_prescaler #(
    .NumSlots (NUM_DIGITS),
    .SlotDiv  (REFRESH_DIV)
  ) u_prescaler (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cnt_o        (cnt),
    .idx_o        (idx),
    .wrap_o       (wrap),
    .frame_wrap_o (frame_wrap)
  );

  assign unused_wrap = wrap;

  logic [DispW-1:0]      disp_q, disp_d;
  logic [DispW-1:0]      shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [NIBBLE_W-1:0]   bcd_q, bcd_d;
  logic                  cs_q, cs_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_tick_q, frame_tick_d;

  logic [NIBBLE_W-1:0]   nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [7:0]            onehot_full;
  logic [NIBBLE_W-1:0]   cur_nib;
  logic                  slot_on;

  // Shadow capture mid-frame; the displayed value only changes at the frame boundary.
  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_wrap) begin
      if (load) begin
        disp_d = value;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  // Split the displayed value into nibbles and flag leading zeros from the top down.
  always_comb begin
    logic all_zero;
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      nib[i] = disp_q[i*NIBBLE_W +: NIBBLE_W];
    end
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero    = all_zero && (nib[i] == '0);
      lz_blank[i] = (LZB != 0) && (i != 0) && all_zero;
    end
  end

  // Output next-state from the current slot; invalid codes never reach the decoder.
  always_comb begin
    onehot_full  = onehot(3'(idx));
    cur_nib      = nib[idx];
    slot_on      = (cnt >= CntW'(BLANK_CYCLES));
    digit_en_d   = slot_on ? onehot_full[NUM_DIGITS-1:0] : '0;
    cs_d         = slot_on && (cur_nib <= BCD_MAX) && !lz_blank[idx];
    bcd_d        = cs_d ? cur_nib : BLANK_NIBBLE;
    frame_tick_d = (idx == '0) && (cnt == '0);
  end

  // Display state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      bcd_q        <= '0;
      cs_q         <= 1'b0;
      digit_en_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      bcd_q        <= bcd_d;
      cs_q         <= cs_d;
      digit_en_q   <= digit_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bcd        = bcd_q;
  assign cs         = cs_q;
  assign digit_en   = digit_en_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule
